adder_rr_arbiter: RTL and testbench
===================================

# adder_rr_arbiter

Shares one 8-bit adder (sum = a + b, modulo 2^WIDTH) among NREQ requesters. Arbitration is round-robin with a valid/ready handshake per requester. Each granted add is captured in a one-entry output register, tagged with the requester index, and held until the consumer accepts it. The block sits between the requester ports of the datapath and the single shared adder instance.

## Interface
- NREQ, 4: number of requesters, 2..8.
- WIDTH, 8: operand and result width.
- IDW, 2: requester index width. Set so that NREQ ≤ 2^IDW.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit i: requester i presents operands.
- req_ready  out  NREQ  one-hot or zero. Bit i: requester i is granted this cycle.
- req_a  in  NREQ*WIDTH  operand a. Requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b, same packing as req_a.
- res_valid  out  1  output register holds a result.
- res_ready  in  1  consumer accepts the result.
- res_id  out  IDW  index of the requester that produced the result.
- res_sum  out  WIDTH  (a + b) mod 2^WIDTH.
- res_carry  out  1  carry-out of the add (see Configuration).
- grant_cnt  out  16  total completed grants since reset. Wraps at 0xFFFF → 0.

## Operation
- Output slot state machine:
  - States: EMPTY (res_valid=0) and FULL (res_valid=1).
  - EMPTY → FULL on a grant.
  - FULL → EMPTY on res_ready with no grant in the same cycle.
  - FULL → FULL on res_ready together with a grant. The register is reloaded (back-to-back).
  - FULL with res_ready=0: outputs hold stable and no grant is issued.
- Slot free condition: free = !res_valid || res_ready.
- Arbitration (combinational):
  - When free, search req_valid starting at index ptr, ascending, wrapping NREQ-1 → 0.
  - The first set bit k gets req_ready[k]=1. All other req_ready bits are 0.
  - When not free, or when no req_valid bit is set, req_ready = 0.
- A transfer happens when req_valid[k] && req_ready[k]. On that clock edge:
  - res_sum is loaded with the low WIDTH bits of a_k + b_k.
  - res_carry is loaded with the carry-out.
  - res_id is loaded with k.
  - ptr ← (k+1) mod NREQ.
  - grant_cnt increments.
- ptr changes only on a transfer. Idle cycles and stalled cycles leave ptr unchanged.
- Width rule: operands are unsigned and the add uses WIDTH+1 internal bits. Example: 0xFF + 0x01 gives res_sum=0x00, res_carry=1.
- req_ready does not depend on res_valid's next value. It depends only on the current res_valid, res_ready, req_valid and ptr, so a combinational path from res_ready to req_ready exists.
- The arbiter does not hold a grant across cycles. A requester that drops req_valid without a transfer loses nothing.

## Timing
- Latency: a transfer at edge n makes res_valid, res_sum, res_carry and res_id valid after edge n.
- Throughput: one add per cycle while res_ready is held at 1.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0…. Any continuously valid requester waits at most NREQ-1 transfers.
- Reset (asynchronous assert, synchronous-style deassert at the next edge) forces:
  - res_valid=0, res_sum=0, res_carry=0, res_id=0;
  - ptr=0, grant_cnt=0.
  - req_ready=0 while rst_n=0.
- Reset mid-operation: a pending undelivered result is discarded and not reported.
- Simultaneous res_ready and grant in FULL: the old result is consumed and the new one loaded on the same edge, with no bubble.

## Configuration
- ADDER_ARB_CARRY_EN:
  - Defined: res_carry carries bit WIDTH of a+b, registered with res_sum.
  - Undefined: no carry register is built and res_carry is tied to 0. The add is plain modulo-2^WIDTH, and res_sum is identical in both builds.

## Test plan
- Reset: hold rst_n=0 with all req_valid=1 → req_ready=0, res_valid=0, grant_cnt=0. Release reset → the first grant goes to requester 0.
- Single requester: req 2 sends a=0x12, b=0x34, res_ready=1 → next cycle res_valid=1, res_id=2, res_sum=0x46, res_carry=0, grant_cnt=1.
- Overflow: a=0xFF, b=0x01 → res_sum=0x00. res_carry=1 with ADDER_ARB_CARRY_EN, 0 without.
- Round-robin: all 4 requesters valid continuously, res_ready=1 → res_id sequence 0,1,2,3,0,1 on consecutive cycles, with no idle cycles.
- Backpressure: fill the slot, then set res_ready=0 for 5 cycles with requests pending → req_ready=0 and outputs stable throughout, ptr unchanged. Raise res_ready → the old result is consumed and the next requester is loaded on the same edge.
- Reset mid-FULL: with res_valid=1 and res_ready=0, assert rst_n=0 for 1 cycle → res_valid=0 immediately, ptr=0, and the discarded result never appears.

Source files
------------

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin arbiter sharing one WIDTH-bit adder among
// NREQ valid/ready requesters, with a one-entry tagged result register.
// Optional feature macro: ADDER_ARB_CARRY_EN (registers the adder carry-out
// on res_carry_o; when undefined res_carry_o is tied low).
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | result slot empty, res_valid_o = 0
// S_FULL  | result slot holds an undelivered result
module adder_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [IDW-1:0]        res_id_o,
  output logic [WIDTH-1:0]      res_sum_o,
  output logic                  res_carry_o,
  output logic [15:0]           grant_cnt_o
);

  typedef enum logic {S_EMPTY, S_FULL} slot_state_e;

  slot_state_e     state_q;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [15:0]     cnt_q;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [NREQ-1:0]  grant_oh;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   cand_idx;
  logic             grant_any;
  logic             slot_free;
  logic             xfer;
  int               cand;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a_i[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b_i[g*WIDTH +: WIDTH];
  end

  // Round-robin search from ptr_q upward, wrapping; first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_oh  = '0;
    grant_id  = '0;
    ptr_d     = ptr_q;
    a_sel     = '0;
    b_sel     = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = cand[IDW-1:0];
      if (!grant_any && req_valid_i[cand_idx]) begin
        grant_any          = 1'b1;
        grant_oh[cand_idx] = 1'b1;
        grant_id           = cand_idx;
        a_sel              = a_arr[cand_idx];
        b_sel              = b_arr[cand_idx];
        if (cand_idx == IDW'(NREQ - 1)) ptr_d = '0;
        else                            ptr_d = cand_idx + 1'b1;
      end
    end
  end

  // Grant only when the slot can take a result; held off entirely during reset.
  assign slot_free   = (state_q == S_EMPTY) || res_ready_i;
  assign xfer        = rst_ni && slot_free && grant_any;
  assign req_ready_o = xfer ? grant_oh : '0;

`ifdef ADDER_ARB_CARRY_EN
  logic [WIDTH:0] sum_full;
  logic           carry_q;
  assign sum_full    = {1'b0, a_sel} + {1'b0, b_sel};
  assign sum_d       = sum_full[WIDTH-1:0];
  assign res_carry_o = carry_q;
`else
  assign sum_d       = a_sel + b_sel;
  assign res_carry_o = 1'b0;
`endif

  // Output slot FSM with the registered result, pointer and grant counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_EMPTY;
      sum_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
`ifdef ADDER_ARB_CARRY_EN
      carry_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_EMPTY: if (xfer) state_q <= S_FULL;
        S_FULL:  if (!xfer && res_ready_i) state_q <= S_EMPTY;
      endcase
      if (xfer) begin
        sum_q <= sum_d;
        id_q  <= grant_id;
        ptr_q <= ptr_d;
        cnt_q <= cnt_q + 16'd1;
`ifdef ADDER_ARB_CARRY_EN
        carry_q <= sum_full[WIDTH];
`endif
      end
    end
  end

  assign res_valid_o = (state_q == S_FULL);
  assign res_id_o    = id_q;
  assign res_sum_o   = sum_q;
  assign grant_cnt_o = cnt_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Scoreboard bench for adder_rr_arbiter: a reference model predicts each
// grant and pushes the expected result; outputs are compared against it.
module tb_adder_rr_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int IDW = 2;
`ifdef ADDER_ARB_CARRY_EN
  localparam bit CARRY_ON = 1'b1;
`else
  localparam bit CARRY_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic res_valid, res_ready, res_carry;
  logic [IDW-1:0] res_id;
  logic [WIDTH-1:0] res_sum;
  logic [15:0] grant_cnt;

  typedef struct {
    int         id;
    logic [7:0] sum;
    logic       carry;
  } exp_t;

  exp_t sb[$];
  int   m_ptr, m_cnt;
  bit   m_full;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  adder_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_id_o(res_id), .res_sum_o(res_sum), .res_carry_o(res_carry),
    .grant_cnt_o(grant_cnt)
  );

  function automatic int pred_grant();
    if (!rst_n) return -1;
    if (m_full && !res_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] rdy_of(int g);
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  task automatic set_ops(int i, logic [7:0] a, logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'($urandom), 8'($urandom));
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr = 0;
    m_cnt = 0;
    m_full = 1'b0;
  endtask

  // Apply the coming clock edge to the model using the current inputs.
  task automatic model_edge();
    int g;
    exp_t e;
    logic [8:0] s9;
    g = pred_grant();
    if (m_full && res_ready) begin
      void'(sb.pop_front());
      m_full = 1'b0;
    end
    if (g >= 0) begin
      s9 = {1'b0, req_a[g*8 +: 8]} + {1'b0, req_b[g*8 +: 8]};
      e.id = g;
      e.sum = s9[7:0];
      e.carry = CARRY_ON ? s9[8] : 1'b0;
      sb.push_back(e);
      m_full = 1'b1;
      m_ptr = (g + 1) % NREQ;
      m_cnt = (m_cnt + 1) & 16'hFFFF;
    end
  endtask

  task automatic next_cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; res_ready = 1'b1; rand_ops();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
    n_checks++;
    if (res_valid !== 1'b0 || res_sum !== 8'h00 || res_id !== 2'd0 || res_carry !== 1'b0)
      $display("FAIL reset_outputs: got v=%b id=%0d sum=%h c=%b want all 0", res_valid, res_id, res_sum, res_carry);
    else n_pass++;
    n_checks++;
    if (grant_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", grant_cnt); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", req_ready); else n_pass++;
    next_cycle();
    req_valid = 4'h0;
    #1;
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_sum !== sb[0].sum)
      $display("FAIL reset_first_result: got v=%b id=%0d sum=%h want v=1 id=0 sum=%h", res_valid, res_id, res_sum, sb[0].sum);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_single();
    req_valid = 4'b0100; res_ready = 1'b1; set_ops(2, 8'h12, 8'h34);
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready); else n_pass++;
    next_cycle();
    req_valid = 4'h0;
    #1;
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd2 || res_sum !== 8'h46 || res_carry !== 1'b0)
      $display("FAIL single_result: got v=%b id=%0d sum=%h c=%b want v=1 id=2 sum=46 c=0", res_valid, res_id, res_sum, res_carry);
    else n_pass++;
    n_checks++;
    if (grant_cnt !== 16'(m_cnt)) $display("FAIL single_cnt: got %0d want %0d", grant_cnt, m_cnt); else n_pass++;
    next_cycle();
  endtask

  task automatic test_overflow();
    logic exp_c;
    exp_c = CARRY_ON;
    req_valid = 4'b0010; res_ready = 1'b1; set_ops(1, 8'hFF, 8'h01);
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL ovf_ready: got %b want 0010", req_ready); else n_pass++;
    next_cycle();
    req_valid = 4'h0;
    #1;
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd1 || res_sum !== 8'h00 || res_carry !== exp_c)
      $display("FAIL ovf_result: got v=%b id=%0d sum=%h c=%b want v=1 id=1 sum=00 c=%b", res_valid, res_id, res_sum, res_carry, exp_c);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; model_reset();
    #2;
    rst_n = 1'b1; req_valid = 4'hF; res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      #1;
      n_checks++;
      if (req_ready !== rdy_of(i % NREQ)) $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, rdy_of(i % NREQ)); else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (sb.size() == 0 || res_valid !== 1'b1 || res_id !== 2'((i - 1) % NREQ) ||
            res_sum !== sb[0].sum || res_carry !== sb[0].carry)
          $display("FAIL rr_result[%0d]: got v=%b id=%0d sum=%h want v=1 id=%0d", i, res_valid, res_id, res_sum, (i - 1) % NREQ);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    exp_t held;
    held = sb[0];
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      #1;
      n_checks++;
      if (req_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b want 0000", i, req_ready); else n_pass++;
      n_checks++;
      if (res_valid !== 1'b1 || res_id !== 2'(held.id) || res_sum !== held.sum || res_carry !== held.carry)
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d sum=%h want v=1 id=%0d sum=%h", i, res_valid, res_id, res_sum, held.id, held.sum);
      else n_pass++;
      next_cycle();
    end
    res_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL bp_release_ready: got %b want 0001", req_ready); else n_pass++;
    next_cycle();
    req_valid = 4'h0;
    #1;
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || res_sum !== sb[0].sum)
      $display("FAIL bp_reload: got v=%b id=%0d sum=%h want v=1 id=0 sum=%h", res_valid, res_id, res_sum, sb[0].sum);
    else n_pass++;
    n_checks++;
    if (grant_cnt !== 16'(m_cnt)) $display("FAIL bp_cnt: got %0d want %0d", grant_cnt, m_cnt); else n_pass++;
    next_cycle();
  endtask

  task automatic test_reset_mid_full();
    req_valid = 4'b1000; res_ready = 1'b0; set_ops(3, 8'hA5, 8'h11);
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) $display("FAIL midrst_fill: got %b want 1000", req_ready); else n_pass++;
    next_cycle();
    req_valid = 4'hF;
    #1;
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd3 || res_sum !== 8'hB6 || req_ready !== 4'b0000)
      $display("FAIL midrst_full: got v=%b id=%0d sum=%h rdy=%b want v=1 id=3 sum=b6 rdy=0000", res_valid, res_id, res_sum, req_ready);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (res_valid !== 1'b0 || req_ready !== 4'b0000 || grant_cnt !== 16'd0)
      $display("FAIL midrst_async: got v=%b rdy=%b cnt=%0d want 0 0000 0", res_valid, req_ready, grant_cnt);
    else n_pass++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'h0; res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (res_valid !== 1'b0) $display("FAIL midrst_discard[%0d]: got v=%b want 0", i, res_valid); else n_pass++;
      next_cycle();
    end
    req_valid = 4'hF; rand_ops();
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL midrst_ptr: got %b want 0001", req_ready); else n_pass++;
    next_cycle();
    req_valid = 4'h0;
    #1;
    n_checks++;
    if (res_valid !== 1'b1 || res_id !== 2'd0 || grant_cnt !== 16'd1)
      $display("FAIL midrst_regrant: got v=%b id=%0d cnt=%0d want v=1 id=0 cnt=1", res_valid, res_id, grant_cnt);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      #1;
      n_checks++;
      if (req_ready !== rdy_of(pred_grant()))
        $display("FAIL rand_ready[%0d]: got %b want %b", i, req_ready, rdy_of(pred_grant()));
      else n_pass++;
      n_checks++;
      if (m_full) begin
        if (res_valid !== 1'b1 || res_id !== 2'(sb[0].id) || res_sum !== sb[0].sum || res_carry !== sb[0].carry)
          $display("FAIL rand_result[%0d]: got v=%b id=%0d sum=%h c=%b want v=1 id=%0d sum=%h c=%b",
                   i, res_valid, res_id, res_sum, res_carry, sb[0].id, sb[0].sum, sb[0].carry);
        else n_pass++;
      end else begin
        if (res_valid !== 1'b0) $display("FAIL rand_empty[%0d]: got v=%b want 0", i, res_valid); else n_pass++;
      end
      n_checks++;
      if (grant_cnt !== 16'(m_cnt)) $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, grant_cnt, m_cnt); else n_pass++;
      next_cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid_full();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
